// File: rtl/ttio_sched_if.sv
// ICB command/response bus between the time-triggered scheduler (master) and memory (slave).
// Both channels transfer on a cycle where valid and ready are high together; a raised valid holds with a stable payload until then.
interface ttio_sched_if #(
    parameter int AW = 32
);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [31:0]   icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic          icb_rsp_err;
    logic [31:0]   icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/ttio_sched.sv
// Time-triggered I/O scheduler: one request slot per channel, released onto a single ICB
// bus when the prescaled timer reaches the slot deadline; completions drain lowest channel first.
module ttio_sched #(
    parameter int NCH = 4,
    parameter int TW  = 32,
    parameter int AW  = 32,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_op,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [TW-1:0]    cfg_wdata,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_ch,
    input  logic             req_read,
    input  logic [AW-1:0]    req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TW-1:0]    req_time,
    ttio_sched_if.master     icb,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [CW-1:0]    done_ch,
    output logic [31:0]      done_rdata,
    output logic             done_err,
    output logic             done_late,
    output logic [TW-1:0]    timer_o,
    output logic [NCH-1:0]   ch_busy,
    output logic [2*NCH-1:0] dbg_st_o
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ISSUED, S_DONE} slot_st_e;

    slot_st_e      st_q    [NCH], st_d    [NCH];
    logic          rd_q    [NCH], rd_d    [NCH];
    logic [AW-1:0] addr_q  [NCH], addr_d  [NCH];
    logic [31:0]   wdata_q [NCH], wdata_d [NCH];
    logic [TW-1:0] dl_q    [NCH], dl_d    [NCH];
    logic          late_q  [NCH], late_d  [NCH];
    logic [31:0]   rdata_q [NCH], rdata_d [NCH];
    logic          err_q   [NCH], err_d   [NCH];

    logic [TW-1:0] period_q, period_d, presc_q, presc_d, timer_q, timer_d;
    logic          cmd_valid_q, cmd_valid_d, cmd_read_q, cmd_read_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [31:0]   cmd_wdata_q, cmd_wdata_d;
    logic [CW-1:0] cur_ch_q, cur_ch_d, sel;
    logic          busy_q, busy_d, rsp_wait_q, rsp_wait_d;
    logic [TW-1:0] presc_last;
    logic          cancel_hit, accept, req_due, cmd_hs, rsp_hs, cand, found;

    // Due once (now - deadline) lands in the lower half of the timer range.
    function automatic logic is_due(input logic [TW-1:0] now_t, input logic [TW-1:0] dl);
        logic [TW-1:0] diff;
        diff = now_t - dl;
        return ~diff[TW-1];
    endfunction

    always_comb begin
        req_ready = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (req_ch == CW'(i) && st_q[i] == S_IDLE) req_ready = 1'b1;
    end

    always_comb begin
        done_valid = 1'b0;
        done_ch    = '0;
        done_rdata = '0;
        done_err   = 1'b0;
        done_late  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (st_q[i] == S_DONE) begin
                done_valid = 1'b1;
                done_ch    = CW'(i);
                done_rdata = rdata_q[i];
                done_err   = err_q[i];
                done_late  = late_q[i];
            end
        end
    end

    always_comb begin
        period_d = period_q; presc_d = presc_q; timer_d = timer_q;
        st_d = st_q; rd_d = rd_q; addr_d = addr_q; wdata_d = wdata_q; dl_d = dl_q;
        late_d = late_q; rdata_d = rdata_q; err_d = err_q;
        cmd_valid_d = cmd_valid_q; cmd_read_d = cmd_read_q; cmd_addr_d = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q; cur_ch_d = cur_ch_q; busy_d = busy_q; rsp_wait_d = rsp_wait_q;
        cand = 1'b0; found = 1'b0; sel = '0;

        presc_last = (period_q > TW'(1)) ? period_q - TW'(1) : '0;
        if (cfg_valid && cfg_op == 2'd0) begin
            period_d = cfg_wdata;
            presc_d  = '0;
        end else if (cfg_valid && cfg_op == 2'd1) begin
            timer_d = '0;
            presc_d = '0;
        end else if (presc_q >= presc_last) begin
            presc_d = '0;
            timer_d = timer_q + TW'(1);
        end else begin
            presc_d = presc_q + TW'(1);
        end

        cancel_hit = cfg_valid && (cfg_op == 2'd2);
        accept     = req_valid && req_ready;
        // Judging dueness on the next timer value lets the command rise on the tick the deadline is reached.
        req_due    = is_due(timer_d, req_time);
        cmd_hs     = cmd_valid_q && icb.icb_cmd_ready;
        rsp_hs     = rsp_wait_q && icb.icb_rsp_valid;

        for (int i = 0; i < NCH; i++) begin
            if (accept && req_ch == CW'(i)) begin
                st_d[i]    = S_ARMED;
                rd_d[i]    = req_read;
                addr_d[i]  = req_addr;
                wdata_d[i] = req_wdata;
                dl_d[i]    = req_time;
                late_d[i]  = is_due(timer_q, req_time) && (timer_q != req_time);
                rdata_d[i] = '0;
                err_d[i]   = 1'b0;
            end else begin
                case (st_q[i])
                    S_ARMED: begin
                        // An ARMED slot owning the bus has its command waiting for ready.
                        if (busy_q && cur_ch_q == CW'(i)) begin
                            if (cmd_hs) st_d[i] = S_ISSUED;
                        end else if (cancel_hit && cfg_ch == CW'(i)) begin
                            st_d[i] = S_IDLE;
                        end else if (addr_q[i][1:0] != 2'b00 && is_due(timer_d, dl_q[i])) begin
                            st_d[i]    = S_DONE;
                            rdata_d[i] = '0;
                            err_d[i]   = 1'b1;
                        end
                    end
                    S_ISSUED: begin
                        if (rsp_hs && cur_ch_q == CW'(i)) begin
                            st_d[i]    = S_DONE;
                            rdata_d[i] = rd_q[i] ? icb.icb_rsp_rdata : 32'h0;
                            err_d[i]   = icb.icb_rsp_err;
                        end
                    end
                    S_DONE: begin
                        if (done_valid && done_ready && done_ch == CW'(i)) st_d[i] = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end

        if (!busy_q) begin
            for (int i = 0; i < NCH; i++) begin
                cand = !(cancel_hit && cfg_ch == CW'(i)) &&
                       ((st_q[i] == S_ARMED && addr_q[i][1:0] == 2'b00 && is_due(timer_d, dl_q[i])) ||
                        (accept && req_ch == CW'(i) && req_addr[1:0] == 2'b00 && req_due));
                if (cand && !found) begin
                    found = 1'b1;
                    sel   = CW'(i);
                end
            end
        end

        if (found) begin
            busy_d      = 1'b1;
            cmd_valid_d = 1'b1;
            cur_ch_d    = sel;
            if (accept && req_ch == sel) begin
                cmd_addr_d  = req_addr;
                cmd_read_d  = req_read;
                cmd_wdata_d = req_wdata;
            end else begin
                cmd_addr_d  = addr_q[sel];
                cmd_read_d  = rd_q[sel];
                cmd_wdata_d = wdata_q[sel];
            end
        end
        if (cmd_hs) begin
            cmd_valid_d = 1'b0;
            rsp_wait_d  = 1'b1;
        end
        if (rsp_hs) begin
            rsp_wait_d = 1'b0;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0; presc_q <= '0; timer_q <= '0;
            cmd_valid_q <= 1'b0; cmd_read_q <= 1'b0; cmd_addr_q <= '0; cmd_wdata_q <= '0;
            cur_ch_q <= '0; busy_q <= 1'b0; rsp_wait_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                st_q[i] <= S_IDLE; rd_q[i] <= 1'b0; addr_q[i] <= '0; wdata_q[i] <= '0;
                dl_q[i] <= '0; late_q[i] <= 1'b0; rdata_q[i] <= '0; err_q[i] <= 1'b0;
            end
        end else begin
            period_q <= period_d; presc_q <= presc_d; timer_q <= timer_d;
            cmd_valid_q <= cmd_valid_d; cmd_read_q <= cmd_read_d; cmd_addr_q <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d; cur_ch_q <= cur_ch_d; busy_q <= busy_d; rsp_wait_q <= rsp_wait_d;
            st_q <= st_d; rd_q <= rd_d; addr_q <= addr_d; wdata_q <= wdata_d;
            dl_q <= dl_d; late_q <= late_d; rdata_q <= rdata_d; err_q <= err_d;
        end
    end

    assign icb.icb_cmd_valid = cmd_valid_q;
    assign icb.icb_cmd_addr  = cmd_addr_q;
    assign icb.icb_cmd_read  = cmd_read_q;
    assign icb.icb_cmd_wdata = cmd_wdata_q;
    assign icb.icb_cmd_wmask = 4'b1111;
    assign icb.icb_rsp_ready = rsp_wait_q;
    assign timer_o           = timer_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_busy[i]         = (st_q[i] != S_IDLE);
            dbg_st_o[2*i +: 2] = st_q[i];
        end
    end
endmodule

// File: tb/tb_ttio_sched.sv
// Directed bench for ttio_sched with an 8-bit timer so wraparound is reachable quickly.
module tb_ttio_sched;
    localparam int NCH = 4;
    localparam int TW  = 8;
    localparam int AW  = 32;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            cfg_valid = 1'b0;
    logic [1:0]      cfg_op = '0;
    logic [CW-1:0]   cfg_ch = '0;
    logic [TW-1:0]   cfg_wdata = '0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [CW-1:0]   req_ch = '0;
    logic            req_read = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic [TW-1:0]   req_time = '0;
    logic            done_valid;
    logic            done_ready = 1'b0;
    logic [CW-1:0]   done_ch;
    logic [31:0]     done_rdata;
    logic            done_err;
    logic            done_late;
    logic [TW-1:0]   timer_o;
    logic [NCH-1:0]  ch_busy;
    logic [2*NCH-1:0] dbg_st_o;

    ttio_sched_if #(.AW(AW)) icb ();

    ttio_sched #(.NCH(NCH), .TW(TW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_op(cfg_op), .cfg_ch(cfg_ch), .cfg_wdata(cfg_wdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_read(req_read),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_time(req_time),
        .icb(icb),
        .done_valid(done_valid), .done_ready(done_ready), .done_ch(done_ch),
        .done_rdata(done_rdata), .done_err(done_err), .done_late(done_late),
        .timer_o(timer_o), .ch_busy(ch_busy), .dbg_st_o(dbg_st_o)
    );

    typedef struct {
        logic [CW-1:0] ch;
        logic          rd;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [TW-1:0] req_at;
        logic [TW-1:0] dl;
        logic [31:0]   rsp_rdata;
        logic          rsp_err;
        logic          exp_issue;
        logic [TW-1:0] exp_t;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic          exp_late;
    } vec_t;

    vec_t vecs [6];
    logic [35:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_timer(input logic [TW-1:0] t);
        int k = 0;
        while (timer_o != t && k < 300) begin step(); k++; end
        if (timer_o != t) timeout("wait_timer");
    endtask

    task automatic wait_cmd();
        int k = 0;
        while (!icb.icb_cmd_valid && k < 40) begin step(); k++; end
        if (!icb.icb_cmd_valid) timeout("wait_cmd");
    endtask

    task automatic wait_done(output bit cmd_seen);
        int k = 0;
        cmd_seen = 1'b0;
        while (!done_valid && k < 40) begin cmd_seen |= icb.icb_cmd_valid; step(); k++; end
        if (!done_valid) timeout("wait_done");
    endtask

    task automatic submit(input logic [CW-1:0] ch, input logic rd, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [TW-1:0] dl);
        req_valid = 1'b1; req_ch = ch; req_read = rd; req_addr = a; req_wdata = wd; req_time = dl;
        #1;
        check("req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        icb.icb_cmd_ready = 1'b1;
        step();
        icb.icb_cmd_ready = 1'b0;
        check("cmd_drop", icb.icb_cmd_valid, 0);
        check("rsp_ready", icb.icb_rsp_ready, 1);
        icb.icb_rsp_valid = 1'b1; icb.icb_rsp_rdata = rdata; icb.icb_rsp_err = err;
        step();
        icb.icb_rsp_valid = 1'b0;
    endtask

    task automatic take_done();
        logic [35:0] e;
        if (exp_q.size() == 0) begin
            timeout("sb_underflow");
        end else begin
            e = exp_q.pop_front();
            check("done_ch", done_ch, e[35:34]);
            check("done_rdata", done_rdata, e[33:2]);
            check("done_err", done_err, e[1]);
            check("done_late", done_late, e[0]);
        end
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit seen;
        wait_timer(v.req_at);
        exp_q.push_back({v.ch, v.exp_rdata, v.exp_err, v.exp_late});
        submit(v.ch, v.rd, v.addr, v.wdata, v.dl);
        check("ch_busy_set", ch_busy[v.ch], 1);
        if (v.exp_issue) begin
            wait_cmd();
            check("issue_time", timer_o, v.exp_t);
            check("cmd_addr", icb.icb_cmd_addr, v.addr);
            check("cmd_read", icb.icb_cmd_read, v.rd);
            check("cmd_wdata", icb.icb_cmd_wdata, v.wdata);
            check("cmd_wmask", icb.icb_cmd_wmask, 4'hF);
            check("rsp_ready_early", icb.icb_rsp_ready, 0);
            step();
            check("cmd_hold", {icb.icb_cmd_valid, icb.icb_cmd_addr}, {1'b1, v.addr});
            respond(v.rsp_rdata, v.rsp_err);
            wait_done(seen);
        end else begin
            wait_done(seen);
            check("no_issue", seen, 0);
            check("done_time", timer_o, v.exp_t);
        end
        take_done();
        check("ch_busy_clr", ch_busy[v.ch], 0);
    endtask

    initial begin
        bit seen;
        icb.icb_cmd_ready = 1'b0; icb.icb_rsp_valid = 1'b0;
        icb.icb_rsp_err = 1'b0; icb.icb_rsp_rdata = '0;

        //            ch    rd    addr          wdata         at     dl     rsp_rdata     err   iss   t      exp_rdata     err   late
        vecs[0] = '{2'd0, 1'b0, 32'h0000_0100, 32'hA5A5_0001, 8'd2,   8'd5,  32'h1234_5678, 1'b0, 1'b1, 8'd5,  32'h0,         1'b0, 1'b0};
        vecs[1] = '{2'd1, 1'b1, 32'h0000_0204, 32'h0,         8'd20,  8'd3,  32'hCAFE_0001, 1'b0, 1'b1, 8'd21, 32'hCAFE_0001, 1'b0, 1'b1};
        vecs[2] = '{2'd2, 1'b1, 32'h0000_0308, 32'h0,         8'd35,  8'd36, 32'h0BAD_F00D, 1'b0, 1'b1, 8'd36, 32'h0BAD_F00D, 1'b0, 1'b0};
        vecs[3] = '{2'd3, 1'b0, 32'h0000_1002, 32'h5555_AAAA, 8'd50,  8'd52, 32'h0,         1'b0, 1'b0, 8'd52, 32'h0,         1'b1, 1'b0};
        vecs[4] = '{2'd3, 1'b1, 32'h0000_040C, 32'h0,         8'd65,  8'd65, 32'hDEAD_BEEF, 1'b1, 1'b1, 8'd66, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[5] = '{2'd1, 1'b0, 32'h0000_0510, 32'h0F0F_0F0F, 8'd250, 8'd4,  32'h7777_7777, 1'b0, 1'b1, 8'd4,  32'h0,         1'b0, 1'b0};

        repeat (3) step();
        check("rst_timer", timer_o, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_cmd_valid", icb.icb_cmd_valid, 0);
        check("rst_rsp_ready", icb.icb_rsp_ready, 0);
        check("rst_done", {done_valid, done_ch, done_rdata, done_err, done_late}, 0);
        check("rst_ch_busy", ch_busy, 0);
        rst_n = 1'b1;
        step();

        // Period register is still 0 here and must count like period 1.
        cfg_valid = 1'b1; cfg_op = 2'd1;
        step();
        cfg_valid = 1'b0;
        repeat (5) step();
        check("period0_timer", timer_o, 5);

        cfg_valid = 1'b1; cfg_op = 2'd0; cfg_wdata = 8'd3;
        step();
        cfg_op = 2'd1;
        step();
        cfg_valid = 1'b0;
        check("restart_timer", timer_o, 0);
        repeat (29) step();
        check("period3_29", timer_o, 9);
        step();
        check("period3_30", timer_o, 10);

        cfg_valid = 1'b1; cfg_op = 2'd0; cfg_wdata = 8'd1;
        step();
        cfg_op = 2'd1;
        step();
        cfg_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Two channels due together: ch1 wins, ch2 waits for ch1's response.
        wait_timer(8'd20);
        submit(2'd2, 1'b1, 32'h0000_0800, 32'h0, 8'd25);
        submit(2'd1, 1'b1, 32'h0000_0900, 32'h0, 8'd25);
        exp_q.push_back({2'd1, 32'h1111_0001, 1'b0, 1'b0});
        exp_q.push_back({2'd2, 32'h2222_0002, 1'b0, 1'b0});
        wait_cmd();
        check("pair_issue_time", timer_o, 25);
        check("pair_first_addr", icb.icb_cmd_addr, 32'h0000_0900);
        respond(32'h1111_0001, 1'b0);
        wait_cmd();
        check("pair_second_addr", icb.icb_cmd_addr, 32'h0000_0800);
        respond(32'h2222_0002, 1'b0);
        step();
        req_ch = 2'd1;
        #1;
        check("ready_while_done", req_ready, 0);
        take_done();
        #1;
        check("ready_after_done", req_ready, 1);
        take_done();

        // Cancel an ARMED slot: it must vanish without ever issuing or completing.
        wait_timer(8'd60);
        submit(2'd0, 1'b0, 32'h0000_0040, 32'h1, 8'd70);
        check("cancel_busy_set", ch_busy[0], 1);
        cfg_valid = 1'b1; cfg_op = 2'd2; cfg_ch = 2'd0;
        step();
        cfg_valid = 1'b0;
        check("cancel_busy_clr", ch_busy[0], 0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin seen |= icb.icb_cmd_valid | done_valid; step(); end
        check("cancel_silent", seen, 0);

        // Reset while a command waits for ready.
        wait_timer(8'd90);
        submit(2'd2, 1'b0, 32'h0000_1000, 32'h9, 8'd90);
        check("pre_rst_cmd", icb.icb_cmd_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_cmd", icb.icb_cmd_valid, 0);
        check("rst_mid_timer", timer_o, 0);
        check("rst_mid_busy", ch_busy, 0);
        step();
        rst_n = 1'b1;
        icb.icb_rsp_valid = 1'b1; icb.icb_rsp_rdata = 32'hFFFF_FFFF;
        step();
        check("post_rst_rsp_ready", icb.icb_rsp_ready, 0);
        step();
        icb.icb_rsp_valid = 1'b0;
        check("post_rst_done", done_valid, 0);
        check("post_rst_busy", ch_busy, 0);
        check("post_rst_ready", req_ready, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
